// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serializes words MSB-first onto x_out and tracks a non-overlapping Mealy 101 detector reference.
// Ports:
//    clk, rst             clock and synchronous active-high reset
//    data_in, len_in      word to serialize and its length in bits (clamped to DATA_W)
//    valid_in, ready_out  word handshake, accepted only in IDLE
//    x_out, x_valid       serial bit stream and its qualifier
//    done                 one-cycle end-of-word pulse
//    exp_z, match_count   expected registered 101 detection and saturating match count
module seq_pattern_tx #(
   parameter int DATA_W = 8,
   parameter int LEN_W  = $clog2(DATA_W) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic [LEN_W-1:0]  len_in,
   input  logic              valid_in,
   output logic              ready_out,
   output logic              x_out,
   output logic              x_valid,
   output logic              done,
   output logic              exp_z,
   output logic [7:0]        match_count
);
   localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
   localparam logic [1:0] M0 = 2'd0, M1 = 2'd1, M2 = 2'd2;
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_W);
   logic [1:0] state, next_state, m, m_next;
   logic [DATA_W-1:0] shreg;
   logic [LEN_W-1:0] cnt, len_c;
   logic hs, det;
   assign hs = valid_in && ready_out;
   assign len_c = (len_in > MAX_LEN) ? MAX_LEN : len_in;
   always_ff @(posedge clk)
      state <= rst ? IDLE : next_state;
   always_comb begin
      next_state = (state == IDLE)  ? (hs ? ((len_c == '0) ? DONE : SHIFT) : IDLE) :
                   (state == SHIFT) ? ((cnt == LEN_W'(1)) ? DONE : SHIFT) : IDLE;
   end
   always_comb begin
      ready_out = (state == IDLE);
      x_valid   = (state == SHIFT);
      x_out     = (state == SHIFT) && shreg[DATA_W-1];
      done      = (state == DONE);
   end
   // Left-align the word so the top bit is always the next one out; cnt holds bits remaining.
   always_ff @(posedge clk) begin
      if (hs) begin
         shreg <= data_in << (MAX_LEN - len_c);
         cnt   <= len_c;
      end else if (state == SHIFT) begin
         shreg <= shreg << 1;
         cnt   <= cnt - LEN_W'(1);
      end
   end
   // Reference detector sees every cycle's x_out, so idle and gap zeros flush partial matches.
   always_comb begin
      det    = (m == M2) && x_out;
      m_next = (m == M0) ? (x_out ? M1 : M0) :
               (m == M1) ? (x_out ? M1 : M2) : M0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         m           <= M0;
         exp_z       <= 1'b0;
         match_count <= 8'd0;
      end else begin
         m     <= m_next;
         exp_z <= det;
         if (det && match_count != 8'hFF) match_count <= match_count + 8'd1;
      end
   end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: directed self-checking bench for seq_pattern_tx.
module tb_seq_pattern_tx;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data_in = '0;
   logic [3:0] len_in = '0;
   logic       valid_in = 1'b0;
   logic       ready_out, x_out, x_valid, done, exp_z;
   logic [7:0] match_count;
   int checks = 0;
   int errors = 0;

   seq_pattern_tx dut (
      .clk(clk), .rst(rst), .data_in(data_in), .len_in(len_in), .valid_in(valid_in),
      .ready_out(ready_out), .x_out(x_out), .x_valid(x_valid), .done(done),
      .exp_z(exp_z), .match_count(match_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      valid_in = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Waits (bounded) for ready, offers one word, returns in cycle 1 after the handshake.
   task automatic offer(input logic [7:0] d, input logic [3:0] l);
      int n = 0;
      while (!ready_out && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (!ready_out) begin
         errors++;
         $display("FAIL offer_timeout: ready_out=%0b required 1", ready_out);
      end
      data_in = d;
      len_in = l;
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({ready_out, x_out, x_valid, done, exp_z} !== 5'b10000 || match_count !== 8'd0) begin
         errors++;
         $display("FAIL reset: rdy/x/xv/done/z=%b cnt=%0d required 10000 cnt=0",
                  {ready_out, x_out, x_valid, done, exp_z}, match_count);
      end
   endtask

   task automatic test_a0();
      logic [7:0] w = 8'hA0;
      logic [4:0] e;
      do_reset();
      offer(8'hA0, 4'd8);
      data_in = 8'hFF;
      len_in = 4'd3;
      for (int c = 1; c <= 11; c++) begin
         e = {(c <= 8) ? w[8-c] : 1'b0, c <= 8, c == 4, c == 9, c >= 10};
         checks++;
         if ({x_out, x_valid, exp_z, done, ready_out} !== e) begin
            errors++;
            $display("FAIL a0_cycle%0d: x/xv/z/done/rdy=%b required %b", c,
                     {x_out, x_valid, exp_z, done, ready_out}, e);
         end
         tick();
      end
      checks++;
      if (match_count !== 8'd1) begin
         errors++;
         $display("FAIL a0_count: %0d required 1", match_count);
      end
   endtask

   task automatic test_nonoverlap();
      logic [4:0] w = 5'b10101;
      do_reset();
      offer(8'h15, 4'd5);
      for (int c = 1; c <= 7; c++) begin
         checks++;
         if (x_out !== ((c <= 5) ? w[5-c] : 1'b0) || exp_z !== (c == 4)) begin
            errors++;
            $display("FAIL nonoverlap_cycle%0d: x=%b z=%b required x=%b z=%b", c, x_out, exp_z,
                     (c <= 5) ? w[5-c] : 1'b0, c == 4);
         end
         tick();
      end
      checks++;
      if (match_count !== 8'd1) begin
         errors++;
         $display("FAIL nonoverlap_count: %0d required 1", match_count);
      end
   endtask

   task automatic test_gap();
      int z = 0;
      do_reset();
      offer(8'h02, 4'd2);
      for (int c = 0; c < 3; c++) begin
         z += int'(exp_z);
         tick();
      end
      offer(8'h01, 4'd1);
      checks++;
      if (x_out !== 1'b1) begin
         errors++;
         $display("FAIL gap_bit: x=%b required 1", x_out);
      end
      for (int c = 0; c < 5; c++) begin
         z += int'(exp_z);
         tick();
      end
      checks++;
      if (z != 0 || match_count !== 8'd0) begin
         errors++;
         $display("FAIL gap_nodetect: pulses=%0d cnt=%0d required 0 0", z, match_count);
      end
   endtask

   task automatic test_len_edges();
      logic [7:0] got = '0;
      int n = 0;
      do_reset();
      offer(8'hFF, 4'd0);
      checks++;
      if ({x_valid, done, ready_out} !== 3'b010) begin
         errors++;
         $display("FAIL len0_c1: xv/done/rdy=%b required 010", {x_valid, done, ready_out});
      end
      tick();
      checks++;
      if ({x_valid, done, ready_out} !== 3'b001) begin
         errors++;
         $display("FAIL len0_c2: xv/done/rdy=%b required 001", {x_valid, done, ready_out});
      end
      offer(8'h96, 4'd12);
      while (!done && n < 20) begin
         if (x_valid) got = {got[6:0], x_out};
         n += int'(x_valid);
         tick();
      end
      checks++;
      if (n != 8 || got !== 8'h96 || !done) begin
         errors++;
         $display("FAIL len12_clamp: bits=%0d word=%h done=%b required 8 96 1", n, got, done);
      end
   endtask

   task automatic test_reset_mid();
      int bad = 0;
      do_reset();
      offer(8'hFF, 4'd8);
      tick();
      tick();
      tick();
      checks++;
      if (x_valid !== 1'b1 || x_out !== 1'b1) begin
         errors++;
         $display("FAIL mid_bit4: xv=%b x=%b required 1 1", x_valid, x_out);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({ready_out, x_valid, done} !== 3'b100 || match_count !== 8'd0) begin
         errors++;
         $display("FAIL mid_reset: rdy/xv/done=%b cnt=%0d required 100 0",
                  {ready_out, x_valid, done}, match_count);
      end
      for (int c = 0; c < 10; c++) begin
         bad += int'(done || x_valid);
         tick();
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL mid_abandon: done/xv cycles=%0d required 0", bad);
      end
   endtask

   task automatic test_back_to_back();
      int z;
      do_reset();
      for (int w = 0; w < 260; w++) begin
         offer(8'hA0, 4'd8);
         z = 0;
         for (int c = 1; c <= 9; c++) begin
            z += int'(exp_z);
            tick();
         end
         checks++;
         if (z != 1 || match_count !== 8'((w + 1 > 255) ? 255 : w + 1) || !ready_out) begin
            errors++;
            $display("FAIL sat_word%0d: pulses=%0d cnt=%0d rdy=%b required 1 %0d 1", w, z,
                     match_count, ready_out, (w + 1 > 255) ? 255 : w + 1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_a0();
      test_nonoverlap();
      test_gap();
      test_len_edges();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
